serial_disp_rx: RTL and testbench



---
 rtl/serial_disp_rx_if.sv | 25 ++
 rtl/serial_disp_rx.sv | 164 ++++++++++++++++
 tb/tb_serial_disp_rx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_disp_rx_if.sv
// Serial display/LED shift-stream bundle: driver-side serial lines plus receiver status.
interface serial_disp_rx_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 8
);
  logic             sclk_in;
  logic             sdat_in;
  logic             sclrn_in;
  logic             sen_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output sclk_in, sdat_in, sclrn_in, sen_in,
    input  data_out, data_valid, frame_err, busy, bit_cnt
  );

  modport slave (
    input  sclk_in, sdat_in, sclrn_in, sen_in,
    output data_out, data_valid, frame_err, busy, bit_cnt
  );
endinterface

// File: rtl/serial_disp_rx.sv
// Oversampling receiver that rebuilds the parallel frame of the display/LED shift chain.
// Optional stall timeout in SHIFT: define SERIAL_DISP_RX_TIMEOUT_EN.
module serial_disp_rx #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic            clk,
  input  logic            rst,
  serial_disp_rx_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("serial_disp_rx: SYNC_STAGES must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(WIDTH) + 64'd1) begin : g_bad_cnt
    $error("serial_disp_rx: CNT_W too narrow for WIDTH");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("serial_disp_rx: TIMEOUT must be non-zero");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, sdat_sync, sclrn_sync, sen_sync;
  logic                   sclk_d, sen_d;
  logic                   sclk_s, sdat_s, clr_s, sen_s;
  logic                   sclk_rise, sen_rise;

  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             valid_q, valid_nxt;
  logic             err_q, err_nxt;

`ifdef SERIAL_DISP_RX_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  logic [STALL_W-1:0] stall, stall_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync  <= '0;
      sdat_sync  <= '0;
      sclrn_sync <= '0;
      sen_sync   <= '0;
      sclk_d     <= 1'b0;
      sen_d      <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_in};
      sdat_sync  <= {sdat_sync[SYNC_STAGES-2:0], bus.sdat_in};
      sclrn_sync <= {sclrn_sync[SYNC_STAGES-2:0], bus.sclrn_in};
      sen_sync   <= {sen_sync[SYNC_STAGES-2:0], bus.sen_in};
      sclk_d     <= sclk_s;
      sen_d      <= sen_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdat_s    = sdat_sync[SYNC_STAGES-1];
  assign clr_s     = ~sclrn_sync[SYNC_STAGES-1];
  assign sen_s     = sen_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sen_rise  = sen_s & ~sen_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      data_q  <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SERIAL_DISP_RX_TIMEOUT_EN
      stall   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      data_q  <= data_nxt;
      cnt     <= cnt_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
`ifdef SERIAL_DISP_RX_TIMEOUT_EN
      stall   <= stall_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
`ifdef SERIAL_DISP_RX_TIMEOUT_EN
    stall_nxt = '0;
`endif
    if (clr_s) begin
      state_nxt = IDLE;
      shreg_nxt = '0;
      cnt_nxt   = '0;
    end else begin
      // Shift first so a bit coinciding with the latch is counted in DONE
      if (sclk_rise) begin
        shreg_nxt = {shreg[WIDTH-2:0], sdat_s};
        cnt_nxt   = (cnt == '1) ? cnt : cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (sclk_rise) state_nxt = SHIFT;
        end
        SHIFT: begin
          if (sen_rise) begin
            state_nxt = DONE;
          end
`ifdef SERIAL_DISP_RX_TIMEOUT_EN
          else if (!sclk_rise) begin
            if (stall == STALL_LAST) begin
              err_nxt   = 1'b1;
              shreg_nxt = '0;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              stall_nxt = stall + 1'b1;
            end
          end
`endif
        end
        DONE: begin
          if (cnt == FULL_CNT) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          // A bit arriving during DONE opens the next frame
          if (sclk_rise) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = SHIFT;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state == SHIFT);
  assign bus.bit_cnt    = cnt;

endmodule

// File: tb/tb_serial_disp_rx.sv
// Directed bench for serial_disp_rx with WIDTH=64; timeout case under SERIAL_DISP_RX_TIMEOUT_EN.
module tb_serial_disp_rx;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   dv_seen = 0;
  int   fe_seen = 0;
  int   exp_dv = 0;
  int   exp_fe = 0;
  int   cyc = 0;
  int   last_shift_cyc = 0;
  int   fe_cyc = 0;
  logic [7:0] prev_cnt = '0;

  always #5 clk = ~clk;

  serial_disp_rx_if #(.WIDTH(64), .CNT_W(8)) bus ();

  serial_disp_rx #(
    .WIDTH(64), .SYNC_STAGES(2), .CNT_W(8), .TIMEOUT(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.data_valid === 1'b1) dv_seen = dv_seen + 1;
    if (bus.frame_err === 1'b1) begin
      fe_seen = fe_seen + 1;
      fe_cyc  = cyc;
    end
    if (bus.bit_cnt !== prev_cnt && bus.bit_cnt !== 8'd0) last_shift_cyc = cyc;
    prev_cnt = bus.bit_cnt;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.sdat_in = b;
    bus.sclk_in = 1'b1;
    tick(4);
    bus.sclk_in = 1'b0;
    tick(4);
  endtask

  task automatic pulse_sen();
    bus.sen_in = 1'b1;
    tick(4);
    bus.sen_in = 1'b0;
    tick(4);
  endtask

  // Sends val[nbits-1:0] MSB first; optionally raises sen together with the last sclk
  task automatic send_frame(input logic [63:0] val, input int nbits, input bit coincide);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i == 0 && coincide) begin
        bus.sdat_in = val[0];
        bus.sclk_in = 1'b1;
        bus.sen_in  = 1'b1;
        tick(4);
        bus.sclk_in = 1'b0;
        bus.sen_in  = 1'b0;
        tick(4);
      end else begin
        send_bit(val[i]);
      end
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_dv"}, 64'(dv_seen), 64'(exp_dv));
    chk({tag, "_fe"}, 64'(fe_seen), 64'(exp_fe));
  endtask

  initial begin
    rst = 1'b1;
    bus.sclk_in  = 1'b0;
    bus.sdat_in  = 1'b0;
    bus.sclrn_in = 1'b1;
    bus.sen_in   = 1'b0;
    tick(3);
    chk("rst_data", bus.data_out, 64'h0);
    chk("rst_valid", 64'(bus.data_valid), 64'h0);
    chk("rst_err", 64'(bus.frame_err), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_cnt", 64'(bus.bit_cnt), 64'h0);
    rst = 1'b0;
    tick(4);

    // Full 64-bit frame
    send_frame(64'h0123456789ABCDEF, 64, 1'b0);
    chk("a_busy_pre", 64'(bus.busy), 64'h1);
    chk("a_cnt_pre", 64'(bus.bit_cnt), 64'd64);
    pulse_sen();
    exp_dv = 1;
    chk_counts("a");
    chk("a_data", bus.data_out, 64'h0123456789ABCDEF);
    chk("a_cnt", 64'(bus.bit_cnt), 64'h0);
    chk("a_busy", 64'(bus.busy), 64'h0);

    // Short frame (63 bits)
    send_frame(64'h7FFF_FFFF_FFFF_FFFF, 63, 1'b0);
    chk("b_cnt_pre", 64'(bus.bit_cnt), 64'd63);
    pulse_sen();
    exp_fe = 1;
    chk_counts("b");
    chk("b_data_held", bus.data_out, 64'h0123456789ABCDEF);

    // sen in IDLE is ignored
    pulse_sen();
    chk_counts("idle_sen");

    // Clear mid-frame then a good frame
    send_frame(64'h3FF, 10, 1'b0);
    chk("c_cnt_pre", 64'(bus.bit_cnt), 64'd10);
    bus.sclrn_in = 1'b0;
    tick(4);
    bus.sclrn_in = 1'b1;
    tick(4);
    chk("c_cnt_clr", 64'(bus.bit_cnt), 64'h0);
    chk("c_busy_clr", 64'(bus.busy), 64'h0);
    chk_counts("c_clr");
    send_frame(64'hFFFF0000AAAA5555, 64, 1'b0);
    pulse_sen();
    exp_dv = 2;
    chk_counts("c");
    chk("c_data", bus.data_out, 64'hFFFF0000AAAA5555);

    // Back-to-back frames, last sclk coincident with sen
    send_frame(64'h1, 64, 1'b1);
    exp_dv = 3;
    chk_counts("d1");
    chk("d1_data", bus.data_out, 64'h1);
    send_frame(64'h8000000000000000, 64, 1'b1);
    exp_dv = 4;
    chk_counts("d2");
    chk("d2_data", bus.data_out, 64'h8000000000000000);
    chk("d2_cnt", 64'(bus.bit_cnt), 64'h0);

    // Next frame's first bit lands in DONE
    send_frame(64'h0F1E2D3C4B5A6978, 64, 1'b0);
    bus.sen_in = 1'b1;
    tick(1);
    send_bit(1'b0);
    bus.sen_in = 1'b0;
    exp_dv = 5;
    chk_counts("e1");
    chk("e1_data", bus.data_out, 64'h0F1E2D3C4B5A6978);
    chk("e1_cnt", 64'(bus.bit_cnt), 64'd1);
    chk("e1_busy", 64'(bus.busy), 64'h1);
    send_frame(64'h13579BDF2468ACE0, 63, 1'b0);
    pulse_sen();
    exp_dv = 6;
    chk_counts("e2");
    chk("e2_data", bus.data_out, 64'h13579BDF2468ACE0);

    // Reset mid-frame
    send_frame(64'h2AAAAAAA, 30, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("f_rst_data", bus.data_out, 64'h0);
    chk("f_rst_cnt", 64'(bus.bit_cnt), 64'h0);
    chk("f_rst_busy", 64'(bus.busy), 64'h0);
    chk("f_rst_valid", 64'(bus.data_valid), 64'h0);
    chk("f_rst_err", 64'(bus.frame_err), 64'h0);
    tick(1);
    rst = 1'b0;
    tick(4);
    send_frame(64'hDEADBEEFCAFEF00D, 64, 1'b0);
    pulse_sen();
    exp_dv = 7;
    chk_counts("f");
    chk("f_data", bus.data_out, 64'hDEADBEEFCAFEF00D);

    // Stalled frame
    send_frame(64'h15, 5, 1'b0);
    tick(1100);
`ifdef SERIAL_DISP_RX_TIMEOUT_EN
    exp_fe = 2;
    chk_counts("g");
    chk("g_latency", 64'(fe_cyc - last_shift_cyc), 64'd1024);
    chk("g_busy", 64'(bus.busy), 64'h0);
    chk("g_cnt", 64'(bus.bit_cnt), 64'h0);
    chk("g_data_held", bus.data_out, 64'hDEADBEEFCAFEF00D);
`else
    chk_counts("g");
    chk("g_busy", 64'(bus.busy), 64'h1);
    chk("g_cnt", 64'(bus.bit_cnt), 64'd5);
    bus.sclrn_in = 1'b0;
    tick(4);
    bus.sclrn_in = 1'b1;
    tick(4);
    chk("g_cnt_clr", 64'(bus.bit_cnt), 64'h0);
    chk_counts("g_clr");
    chk("g_data_held", bus.data_out, 64'hDEADBEEFCAFEF00D);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
